// File: rtl/led_scan_decoder.sv
// 3-to-8 style LED driver: one-hot decode, thermometer, auto-scan and blink modes, active-low outputs.
// led is registered (one-cycle latency); no backpressure, enable only gates the outputs and freezes scan/blink state.
module led_scan_decoder #(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              enable,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        switch,
  output logic [(2**SEL_W)-1:0]   led
);

  localparam int LED_W = 2**SEL_W;
  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  localparam logic [1:0] MODE_DECODE = 2'd0;
  localparam logic [1:0] MODE_THERMO = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // 74138-style gate: G1 high, both G2 strobes low
  localparam logic [2:0] ENABLE_ON = 3'b100;

  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             phase, phase_nxt;
  logic [1:0]       prev_mode;
  logic [LED_W-1:0] led_nxt;

  logic             gate_on;
  logic             entry;
  logic             tick;
  logic [SEL_W-1:0] ptr_inc;
  logic [CNT_W-1:0] cnt_inc;
  logic [LED_W-1:0] sel_onehot;
  logic [LED_W-1:0] ptr_onehot;
  logic [LED_W-1:0] ptr_inc_onehot;
  logic [LED_W-1:0] therm;

  assign gate_on        = (enable == ENABLE_ON);
  assign entry          = (mode != prev_mode);
  assign tick           = (cnt == CNT_MAX);
  // LED_W is a power of two, so the natural SEL_W overflow gives the LED_W-1 -> 0 wrap
  assign ptr_inc        = ptr + SEL_W'(1);
  assign cnt_inc        = cnt + CNT_W'(1);
  assign sel_onehot     = LED_W'(1) << switch;
  assign ptr_onehot     = LED_W'(1) << ptr;
  assign ptr_inc_onehot = LED_W'(1) << ptr_inc;

  always_comb begin
    therm = '1;
    for (int i = 0; i < LED_W; i++) begin
      therm[i] = (i > int'(switch));
    end
  end

  always_comb begin
    led_nxt   = '1;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (gate_on) begin
      case (mode)
        MODE_DECODE: begin
          led_nxt = ~sel_onehot;
          cnt_nxt = '0;
        end
        MODE_THERMO: begin
          led_nxt = therm;
          cnt_nxt = '0;
        end
        MODE_SCAN: begin
          if (entry) begin
            ptr_nxt = switch;
            cnt_nxt = '0;
            led_nxt = ~sel_onehot;
          end else if (tick) begin
            ptr_nxt = ptr_inc;
            cnt_nxt = '0;
            led_nxt = ~ptr_inc_onehot;
          end else begin
            cnt_nxt = cnt_inc;
            led_nxt = ~ptr_onehot;
          end
        end
        default: begin
          if (entry) begin
            phase_nxt = 1'b1;
            cnt_nxt   = '0;
          end else if (tick) begin
            phase_nxt = ~phase;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt_inc;
          end
          // switch is live in blink mode, only the phase is stateful
          led_nxt = phase_nxt ? ~sel_onehot : '1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led       <= '1;
      ptr       <= '0;
      cnt       <= '0;
      phase     <= 1'b1;
      prev_mode <= MODE_DECODE;
    end else begin
      led       <= led_nxt;
      ptr       <= ptr_nxt;
      cnt       <= cnt_nxt;
      phase     <= phase_nxt;
      prev_mode <= mode;
    end
  end

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed and random-regression bench for led_scan_decoder (SEL_W=3, PRESCALE=4).
module tb_led_scan_decoder;

  logic       clk;
  logic       rst;
  logic [2:0] enable;
  logic [1:0] mode;
  logic [2:0] switch;
  logic [7:0] led;

  int checks = 0;
  int fails  = 0;

  logic [7:0] dec_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [2:0] bad_en  [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

  // reference model state for the random regression
  logic [2:0] m_ptr;
  logic [1:0] m_cnt;
  logic       m_phase;
  logic [1:0] m_prev;
  logic [7:0] m_led;

  led_scan_decoder #(.SEL_W(3), .PRESCALE(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .mode   (mode),
    .switch (switch),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3'd0; m_cnt = 2'd0; m_phase = 1'b1; m_prev = 2'd0; m_led = 8'hFF;
  endtask

  task automatic model_edge();
    logic ent, tk;
    ent = (mode != m_prev);
    tk  = (m_cnt == 2'd3);
    if (enable != 3'b100) begin
      m_led = 8'hFF;
    end else if (mode == 2'd0) begin
      m_led = 8'hFF ^ (8'h01 << switch);
      m_cnt = 2'd0;
    end else if (mode == 2'd1) begin
      m_led = 8'hFF << (int'(switch) + 1);
      m_cnt = 2'd0;
    end else if (mode == 2'd2) begin
      if (ent) begin m_ptr = switch; m_cnt = 2'd0; end
      else if (tk) begin m_ptr = m_ptr + 3'd1; m_cnt = 2'd0; end
      else m_cnt = m_cnt + 2'd1;
      m_led = 8'hFF ^ (8'h01 << m_ptr);
    end else begin
      if (ent) begin m_phase = 1'b1; m_cnt = 2'd0; end
      else if (tk) begin m_phase = ~m_phase; m_cnt = 2'd0; end
      else m_cnt = m_cnt + 2'd1;
      m_led = m_phase ? (8'hFF ^ (8'h01 << switch)) : 8'hFF;
    end
    m_prev = mode;
  endtask

  initial begin
    rst = 1'b1; enable = 3'b000; mode = 2'd0; switch = 3'd0;
    #1 rst = 1'b0;
    #1 chk("reset_initial", led, 8'hFF);
    step();
    step();
    chk("reset_held", led, 8'hFF);
    rst = 1'b1;

    // decode sweep
    enable = 3'b100;
    for (int s = 0; s < 8; s++) begin
      switch = 3'(s);
      step();
      chk($sformatf("decode_sw%0d", s), led, dec_tab[s]);
    end
    switch = 3'd3;
    for (int e = 0; e < 7; e++) begin
      enable = bad_en[e];
      step();
      chk($sformatf("disabled_en%0d", bad_en[e]), led, 8'hFF);
    end
    enable = 3'b100;

    // thermometer
    mode = 2'd1; switch = 3'd2; step(); chk("thermo_sw2", led, 8'hF8);
    switch = 3'd7; step(); chk("thermo_sw7", led, 8'h00);
    switch = 3'd0; step(); chk("thermo_sw0", led, 8'hFE);

    // async reset between edges
    switch = 3'd7; step(); chk("thermo_pre_reset", led, 8'h00);
    rst = 1'b0;
    #1 chk("async_reset", led, 8'hFF);
    step(); chk("reset_during_edge", led, 8'hFF);
    rst = 1'b1;

    // scan wrap from 6; switch changes after entry are ignored
    mode = 2'd0; switch = 3'd6; step(); chk("decode_before_scan", led, 8'hBF);
    mode = 2'd2;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 0) switch = 3'd3;
      chk($sformatf("scan_%0d", i), led, (i < 4) ? 8'hBF : (i < 8) ? 8'h7F : 8'hFE);
    end

    // blink, then disable mid-period and resume
    mode = 2'd3; switch = 3'd1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("blink_%0d", i), led, (i < 4 || i >= 8) ? 8'hFD : 8'hFF);
    end
    enable = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("blink_off_%0d", i), led, 8'hFF);
    end
    enable = 3'b100;
    step(); chk("blink_resume_0", led, 8'hFD);
    step(); chk("blink_resume_1", led, 8'hFD);
    step(); chk("blink_resume_2", led, 8'hFF);
    step(); chk("blink_resume_3", led, 8'hFF);
    step(); chk("blink_resume_4", led, 8'hFF);
    step(); chk("blink_resume_5", led, 8'hFF);
    switch = 3'd5;
    step(); chk("blink_live_switch", led, 8'hDF);
    switch = 3'd0;
    step(); chk("blink_live_switch2", led, 8'hFE);

    // reset mid-blink; first edge after release is a fresh entry
    rst = 1'b0;
    #1 chk("reset_mid_blink", led, 8'hFF);
    step();
    rst = 1'b1;
    switch = 3'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("blink_after_reset_%0d", i), led, (i < 4) ? 8'hFD : 8'hFF);
    end

    // random regression against the reference model
    rst = 1'b0;
    #1;
    model_reset();
    step();
    rst = 1'b1;
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b100;
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      switch = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 10) == 0) begin
        rst = 1'b0;
        #1;
        model_reset();
        chk($sformatf("rand_reset_%0d", n), led, m_led);
        step();
        chk($sformatf("rand_reset_edge_%0d", n), led, m_led);
        rst = 1'b1;
      end else begin
        model_edge();
        step();
        chk($sformatf("rand_%0d", n), led, m_led);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
